// File: rtl/iter_muldiv.sv
// Iterative radix-2 multiply/divide unit owning HI/LO, with a start/busy/done handshake.
// Optional MADD/MSUB accumulate ops are enabled by defining ITER_MULDIV_MACC_EN.
module iter_muldiv #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [2:0]       mdu_op,
   input  logic [WIDTH-1:0] opr1,
   input  logic [WIDTH-1:0] opr2,
   input  logic             abort,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int unsigned CNT_W = $clog2(WIDTH + 1);
   localparam int unsigned ACC_W = 2 * WIDTH + 1;
   localparam int unsigned PRD_W = 2 * WIDTH;

   localparam logic [2:0] OP_MULT  = 3'b000;
   localparam logic [2:0] OP_MULTU = 3'b001;
   localparam logic [2:0] OP_DIV   = 3'b010;
   localparam logic [2:0] OP_DIVU  = 3'b011;
   localparam logic [2:0] OP_MTHI  = 3'b100;
   localparam logic [2:0] OP_MTLO  = 3'b101;
`ifdef ITER_MULDIV_MACC_EN
   localparam logic [2:0] OP_MADD  = 3'b110;
   localparam logic [2:0] OP_MSUB  = 3'b111;
`endif

   typedef enum logic [1:0] {
      S_IDLE,
      S_CALC,
      S_FIXUP,
      S_ACCUM
   } state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] opnd_q, opnd_d;
   logic [WIDTH-1:0] src1_q, src1_d;
   logic             is_div_q, is_div_d;
   logic             neg_q_q, neg_q_d;
   logic             neg_r_q, neg_r_d;
   logic             dz_q, dz_d;
   logic             macc_q, macc_d;
   logic             msub_q, msub_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             div_zero_q, div_zero_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;

   // Operation decode and operand magnitudes (most-negative maps to 2^(WIDTH-1))
   logic             op_mul_c, op_div_c, op_macc_c, op_signed_c, s1_c, s2_c;
   logic [WIDTH-1:0] mag1_c, mag2_c;

   always_comb begin
      op_macc_c   = 1'b0;
`ifdef ITER_MULDIV_MACC_EN
      op_macc_c   = (mdu_op == OP_MADD) || (mdu_op == OP_MSUB);
`endif
      op_mul_c    = (mdu_op == OP_MULT) || (mdu_op == OP_MULTU);
      op_div_c    = (mdu_op == OP_DIV) || (mdu_op == OP_DIVU);
      op_signed_c = (mdu_op == OP_MULT) || (mdu_op == OP_DIV) || op_macc_c;
      s1_c        = op_signed_c & opr1[WIDTH-1];
      s2_c        = op_signed_c & opr2[WIDTH-1];
      mag1_c      = s1_c ? WIDTH'(-opr1) : opr1;
      mag2_c      = s2_c ? WIDTH'(-opr2) : opr2;
   end

   // One radix-2 step of shift-add multiply and restoring divide, plus result fixups
   logic [WIDTH:0]   mul_sum_c, div_rem_c, div_diff_c;
   logic [ACC_W-1:0] mul_next_c, div_sh_c, div_next_c;
   logic [PRD_W-1:0] prod_fix_c, macc_sum_c;
   logic [WIDTH-1:0] quo_fix_c, rem_fix_c;

   always_comb begin
      mul_sum_c  = acc_q[ACC_W-1:WIDTH] + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
      mul_next_c = {1'b0, mul_sum_c, acc_q[WIDTH-1:1]};
      div_sh_c   = {acc_q[ACC_W-2:0], 1'b0};
      div_rem_c  = div_sh_c[ACC_W-1:WIDTH];
      div_diff_c = div_rem_c - {1'b0, opnd_q};
      div_next_c = (div_rem_c >= {1'b0, opnd_q}) ?
                   {div_diff_c, div_sh_c[WIDTH-1:1], 1'b1} : div_sh_c;
      prod_fix_c = neg_q_q ? PRD_W'(-acc_q[PRD_W-1:0]) : acc_q[PRD_W-1:0];
      quo_fix_c  = neg_q_q ? WIDTH'(-acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
      rem_fix_c  = neg_r_q ? WIDTH'(-acc_q[PRD_W-1:WIDTH]) : acc_q[PRD_W-1:WIDTH];
      macc_sum_c = msub_q ? ({hi_q, lo_q} - acc_q[PRD_W-1:0])
                          : ({hi_q, lo_q} + acc_q[PRD_W-1:0]);
   end

   // Next-state and datapath control
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      acc_d      = acc_q;
      opnd_d     = opnd_q;
      src1_d     = src1_q;
      is_div_d   = is_div_q;
      neg_q_d    = neg_q_q;
      neg_r_d    = neg_r_q;
      dz_d       = dz_q;
      macc_d     = macc_q;
      msub_d     = msub_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      div_zero_d = div_zero_q;
      hi_d       = hi_q;
      lo_d       = lo_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (op_mul_c || op_div_c || op_macc_c) begin
                  state_d  = S_CALC;
                  busy_d   = 1'b1;
                  cnt_d    = CNT_W'(WIDTH);
                  is_div_d = op_div_c;
                  neg_q_d  = s1_c ^ s2_c;
                  neg_r_d  = s1_c;
                  dz_d     = op_div_c && (opr2 == '0);
                  macc_d   = op_macc_c;
                  msub_d   = mdu_op[0];
                  src1_d   = opr1;
                  opnd_d   = op_div_c ? mag2_c : mag1_c;
                  acc_d    = {{(WIDTH+1){1'b0}}, (op_div_c ? mag1_c : mag2_c)};
               end else begin
                  // Moves complete in one cycle; unsupported codes just acknowledge
                  done_d     = 1'b1;
                  div_zero_d = 1'b0;
                  if (mdu_op == OP_MTHI) hi_d = opr1;
                  if (mdu_op == OP_MTLO) lo_d = opr1;
               end
            end
         end

         S_CALC: begin
            if (abort) begin
               state_d = S_IDLE;
               busy_d  = 1'b0;
               cnt_d   = '0;
            end else begin
               acc_d = is_div_q ? div_next_c : mul_next_c;
               cnt_d = cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) state_d = S_FIXUP;
            end
         end

         S_FIXUP: begin
            if (abort) begin
               state_d = S_IDLE;
               busy_d  = 1'b0;
            end else if (macc_q) begin
               acc_d   = {1'b0, prod_fix_c};
               state_d = S_ACCUM;
            end else begin
               state_d    = S_IDLE;
               busy_d     = 1'b0;
               done_d     = 1'b1;
               div_zero_d = dz_q;
               if (!is_div_q) begin
                  {hi_d, lo_d} = prod_fix_c;
               end else if (dz_q) begin
                  hi_d = src1_q;
                  lo_d = '1;
               end else begin
                  hi_d = rem_fix_c;
                  lo_d = quo_fix_c;
               end
            end
         end

         S_ACCUM: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            if (!abort) begin
               {hi_d, lo_d} = macc_sum_c;
               done_d       = 1'b1;
               div_zero_d   = 1'b0;
            end
         end

         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         acc_q      <= '0;
         opnd_q     <= '0;
         src1_q     <= '0;
         is_div_q   <= 1'b0;
         neg_q_q    <= 1'b0;
         neg_r_q    <= 1'b0;
         dz_q       <= 1'b0;
         macc_q     <= 1'b0;
         msub_q     <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         div_zero_q <= 1'b0;
         hi_q       <= '0;
         lo_q       <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         acc_q      <= acc_d;
         opnd_q     <= opnd_d;
         src1_q     <= src1_d;
         is_div_q   <= is_div_d;
         neg_q_q    <= neg_q_d;
         neg_r_q    <= neg_r_d;
         dz_q       <= dz_d;
         macc_q     <= macc_d;
         msub_q     <= msub_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         div_zero_q <= div_zero_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign div_zero = div_zero_q;
   assign hi       = hi_q;
   assign lo       = lo_q;

endmodule

// File: tb/tb_iter_muldiv.sv
// Self-checking bench for iter_muldiv: randomized and directed ops against an arithmetic model of HI/LO.
module tb_iter_muldiv;

   localparam int unsigned W = 32;

`ifdef ITER_MULDIV_MACC_EN
   localparam bit MACC = 1'b1;
`else
   localparam bit MACC = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n, start, abort;
   logic [2:0]    mdu_op;
   logic [W-1:0]  opr1, opr2;
   logic          busy, done, div_zero;
   logic [W-1:0]  hi, lo;

   int errors = 0;
   int checks = 0;

   logic [W-1:0]  m_hi, m_lo;
   logic          m_dz;

   always #5 clk = ~clk;

   iter_muldiv #(.WIDTH(W)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .mdu_op   (mdu_op),
      .opr1     (opr1),
      .opr2     (opr2),
      .abort    (abort),
      .busy     (busy),
      .done     (done),
      .div_zero (div_zero),
      .hi       (hi),
      .lo       (lo)
   );

   // Reference: plain 64-bit arithmetic on the architectural HI/LO pair
   function automatic void model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      longint      sa, sb;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      m_dz = 1'b0;
      case (op)
         3'd0: begin p = 64'(sa * sb); {m_hi, m_lo} = p; end
         3'd1: begin p = {32'b0, a} * {32'b0, b}; {m_hi, m_lo} = p; end
         3'd2: begin
            if (b == '0) begin m_hi = a; m_lo = '1; m_dz = 1'b1; end
            else begin m_lo = 32'(sa / sb); m_hi = 32'(sa % sb); end
         end
         3'd3: begin
            if (b == '0) begin m_hi = a; m_lo = '1; m_dz = 1'b1; end
            else begin m_lo = a / b; m_hi = a % b; end
         end
         3'd4: m_hi = a;
         3'd5: m_lo = a;
         default: begin
            if (MACC) begin
               p = (op == 3'd6) ? ({m_hi, m_lo} + 64'(sa * sb)) : ({m_hi, m_lo} - 64'(sa * sb));
               {m_hi, m_lo} = p;
            end
         end
      endcase
   endfunction

   function automatic int exp_lat(input logic [2:0] op);
      if (op < 3'd4) return int'(W) + 1;
      if (op >= 3'd6 && MACC) return int'(W) + 2;
      return 0;
   endfunction

   function automatic bit exp_busy(input logic [2:0] op);
      return (op < 3'd4) || (op >= 3'd6 && MACC);
   endfunction

   function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 5))
         0:       return '0;
         1:       return 32'd1;
         2:       return '1;
         3:       return 32'h8000_0000;
         default: return W'($urandom);
      endcase
   endfunction

   // Issue one op and poll (edges after the accepting edge) until done, bounded
   task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output int lat, output bit saw_busy, output bit overlap);
      @(negedge clk);
      start = 1'b1; mdu_op = op; opr1 = a; opr2 = b;
      @(posedge clk); #1;
      start = 1'b0;
      lat = -1; saw_busy = 1'b0; overlap = 1'b0;
      for (int n = 0; n <= 80; n++) begin
         if (busy) saw_busy = 1'b1;
         if (busy && done) overlap = 1'b1;
         if (done) begin lat = n; break; end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (done !== 1'b0)     begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
      checks++; if (div_zero !== 1'b0) begin errors++; $display("FAIL reset_div_zero got=%b exp=0", div_zero); end
      checks++; if (hi !== '0)         begin errors++; $display("FAIL reset_hi got=%h exp=0", hi); end
      checks++; if (lo !== '0)         begin errors++; $display("FAIL reset_lo got=%h exp=0", lo); end
      @(negedge clk);
      rst_n = 1'b1;
      m_hi = '0; m_lo = '0; m_dz = 1'b0;
   endtask

   task automatic test_directed();
      logic [2:0]   ops [8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd2, 3'd2, 3'd0};
      logic [W-1:0] as  [8] = '{32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFF9, 32'd7,
                                32'h1234, 32'h8000_0000, 32'hFFFF_FFFB, 32'h8000_0000};
      logic [W-1:0] bs  [8] = '{32'd3, 32'd3, 32'd2, 32'd2, 32'd0, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000};
      int lat; bit sb, ov;
      for (int i = 0; i < 8; i++) begin
         run_op(ops[i], as[i], bs[i], lat, sb, ov);
         model(ops[i], as[i], bs[i]);
         checks++; if (lat !== exp_lat(ops[i])) begin errors++; $display("FAIL directed_lat[%0d] got=%0d exp=%0d", i, lat, exp_lat(ops[i])); end
         checks++; if (hi !== m_hi)             begin errors++; $display("FAIL directed_hi[%0d] got=%h exp=%h", i, hi, m_hi); end
         checks++; if (lo !== m_lo)             begin errors++; $display("FAIL directed_lo[%0d] got=%h exp=%h", i, lo, m_lo); end
         checks++; if (div_zero !== m_dz)       begin errors++; $display("FAIL directed_dz[%0d] got=%b exp=%b", i, div_zero, m_dz); end
         checks++; if (ov !== 1'b0)             begin errors++; $display("FAIL directed_busy_done[%0d] got=%b exp=0", i, ov); end
      end
   endtask

   task automatic test_random();
      logic [2:0]   op;
      logic [W-1:0] a, b;
      int lat; bit sb, ov;
      for (int i = 0; i < 30; i++) begin
         op = 3'($urandom_range(0, 7));
         a  = pick();
         b  = pick();
         run_op(op, a, b, lat, sb, ov);
         model(op, a, b);
         checks++; if (lat !== exp_lat(op))  begin errors++; $display("FAIL random_lat[%0d] op=%0d got=%0d exp=%0d", i, op, lat, exp_lat(op)); end
         checks++; if (sb !== exp_busy(op))  begin errors++; $display("FAIL random_busy[%0d] op=%0d got=%b exp=%b", i, op, sb, exp_busy(op)); end
         checks++; if ({hi, lo} !== {m_hi, m_lo}) begin errors++; $display("FAIL random_hilo[%0d] op=%0d a=%h b=%h got=%h_%h exp=%h_%h", i, op, a, b, hi, lo, m_hi, m_lo); end
         checks++; if (div_zero !== m_dz)    begin errors++; $display("FAIL random_dz[%0d] got=%b exp=%b", i, div_zero, m_dz); end
         checks++; if (ov !== 1'b0)          begin errors++; $display("FAIL random_busy_done[%0d] got=%b exp=0", i, ov); end
      end
   endtask

   task automatic test_move();
      int lat; bit sb, ov;
      run_op(3'd4, 32'hA5A5_A5A5, 32'd0, lat, sb, ov);
      model(3'd4, 32'hA5A5_A5A5, 32'd0);
      checks++; if (lat !== 0)     begin errors++; $display("FAIL mthi_lat got=%0d exp=0", lat); end
      checks++; if (sb !== 1'b0)   begin errors++; $display("FAIL mthi_busy got=%b exp=0", sb); end
      checks++; if (hi !== m_hi)   begin errors++; $display("FAIL mthi_hi got=%h exp=%h", hi, m_hi); end
      run_op(3'd5, 32'h5A5A_5A5A, 32'd0, lat, sb, ov);
      model(3'd5, 32'h5A5A_5A5A, 32'd0);
      checks++; if (lat !== 0)     begin errors++; $display("FAIL mtlo_lat got=%0d exp=0", lat); end
      checks++; if (sb !== 1'b0)   begin errors++; $display("FAIL mtlo_busy got=%b exp=0", sb); end
      checks++; if ({hi, lo} !== {m_hi, m_lo}) begin errors++; $display("FAIL mtlo_hilo got=%h_%h exp=%h_%h", hi, lo, m_hi, m_lo); end
      @(posedge clk); #1;
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL move_done_pulse got=%b exp=0", done); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL move_busy_after got=%b exp=0", busy); end
   endtask

   task automatic test_back_to_back();
      int lat; bit sb, ov;
      run_op(3'd0, 32'd12345, 32'hFFFF_FF00, lat, sb, ov);
      model(3'd0, 32'd12345, 32'hFFFF_FF00);
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_first_done got=%b exp=1", done); end
      run_op(3'd3, 32'd1000, 32'd7, lat, sb, ov);
      model(3'd3, 32'd1000, 32'd7);
      checks++; if (lat !== int'(W) + 1) begin errors++; $display("FAIL b2b_lat got=%0d exp=%0d", lat, int'(W) + 1); end
      checks++; if ({hi, lo} !== {m_hi, m_lo}) begin errors++; $display("FAIL b2b_hilo got=%h_%h exp=%h_%h", hi, lo, m_hi, m_lo); end
      @(posedge clk); #1;
      checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL b2b_idle got=%b exp=00", {busy, done}); end
   endtask

   task automatic test_abort();
      bit seen_done, busy_pre, busy_post;
      int lat;
      @(negedge clk);
      start = 1'b1; mdu_op = 3'd0; opr1 = 32'h0BAD_F00D; opr2 = 32'h7777_1234;
      @(posedge clk); #1;
      start = 1'b0;
      seen_done = 1'b0; busy_pre = 1'b0; busy_post = 1'b1;
      for (int n = 0; n <= 50; n++) begin
         if (n == 10) begin busy_pre = busy; abort = 1'b1; end
         if (n == 11) begin abort = 1'b0; busy_post = busy; end
         if (done) seen_done = 1'b1;
         @(posedge clk); #1;
      end
      checks++; if (busy_pre !== 1'b1)  begin errors++; $display("FAIL abort_busy_before got=%b exp=1", busy_pre); end
      checks++; if (busy_post !== 1'b0) begin errors++; $display("FAIL abort_busy_after got=%b exp=0", busy_post); end
      checks++; if (seen_done !== 1'b0) begin errors++; $display("FAIL abort_no_done got=%b exp=0", seen_done); end
      checks++; if ({hi, lo} !== {m_hi, m_lo}) begin errors++; $display("FAIL abort_hilo got=%h_%h exp=%h_%h", hi, lo, m_hi, m_lo); end

      // A start while busy must neither disturb nor queue behind the first op
      @(negedge clk);
      start = 1'b1; mdu_op = 3'd3; opr1 = 32'hDEAD_0001; opr2 = 32'd13;
      @(posedge clk); #1;
      start = 1'b0;
      lat = -1;
      for (int n = 0; n <= 80; n++) begin
         if (n == 5) begin start = 1'b1; mdu_op = 3'd0; opr1 = W'($urandom); opr2 = W'($urandom); end
         if (n == 6) start = 1'b0;
         if (done) begin lat = n; break; end
         @(posedge clk); #1;
      end
      model(3'd3, 32'hDEAD_0001, 32'd13);
      checks++; if (lat !== int'(W) + 1) begin errors++; $display("FAIL ignore_start_lat got=%0d exp=%0d", lat, int'(W) + 1); end
      checks++; if ({hi, lo} !== {m_hi, m_lo}) begin errors++; $display("FAIL ignore_start_hilo got=%h_%h exp=%h_%h", hi, lo, m_hi, m_lo); end
      @(posedge clk); #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ignore_start_no_queue got=%b exp=0", busy); end
   endtask

   task automatic test_macc();
      int lat; bit sb, ov;
`ifdef ITER_MULDIV_MACC_EN
      run_op(3'd4, 32'd0, 32'd0, lat, sb, ov);  model(3'd4, 32'd0, 32'd0);
      run_op(3'd5, 32'd10, 32'd0, lat, sb, ov); model(3'd5, 32'd10, 32'd0);
      run_op(3'd6, 32'd3, 32'd4, lat, sb, ov);  model(3'd6, 32'd3, 32'd4);
      checks++; if (lat !== int'(W) + 2) begin errors++; $display("FAIL madd_lat got=%0d exp=%0d", lat, int'(W) + 2); end
      checks++; if ({hi, lo} !== {m_hi, m_lo}) begin errors++; $display("FAIL madd_hilo got=%h_%h exp=%h_%h", hi, lo, m_hi, m_lo); end
      run_op(3'd7, 32'd5, 32'd5, lat, sb, ov);  model(3'd7, 32'd5, 32'd5);
      checks++; if (lat !== int'(W) + 2) begin errors++; $display("FAIL msub_lat got=%0d exp=%0d", lat, int'(W) + 2); end
      checks++; if ({hi, lo} !== {m_hi, m_lo}) begin errors++; $display("FAIL msub_hilo got=%h_%h exp=%h_%h", hi, lo, m_hi, m_lo); end
      checks++; if (ov !== 1'b0) begin errors++; $display("FAIL msub_busy_done got=%b exp=0", ov); end
`else
      run_op(3'd3, 32'h55, 32'd0, lat, sb, ov); model(3'd3, 32'h55, 32'd0);
      checks++; if (div_zero !== 1'b1) begin errors++; $display("FAIL noop_setup_dz got=%b exp=1", div_zero); end
      for (int i = 6; i < 8; i++) begin
         run_op(3'(i), 32'd3, 32'd4, lat, sb, ov);
         model(3'(i), 32'd3, 32'd4);
         checks++; if (lat !== 0)       begin errors++; $display("FAIL noop_lat[%0d] got=%0d exp=0", i, lat); end
         checks++; if (sb !== 1'b0)     begin errors++; $display("FAIL noop_busy[%0d] got=%b exp=0", i, sb); end
         checks++; if ({hi, lo} !== {m_hi, m_lo}) begin errors++; $display("FAIL noop_hilo[%0d] got=%h_%h exp=%h_%h", i, hi, lo, m_hi, m_lo); end
         checks++; if (div_zero !== 1'b0) begin errors++; $display("FAIL noop_dz[%0d] got=%b exp=0", i, div_zero); end
      end
`endif
   endtask

   task automatic test_async_reset();
      int lat; bit sb, ov;
      run_op(3'd4, 32'hDEAD_BEEF, 32'd0, lat, sb, ov); model(3'd4, 32'hDEAD_BEEF, 32'd0);
      run_op(3'd3, 32'h0000_4321, 32'd0, lat, sb, ov); model(3'd3, 32'h0000_4321, 32'd0);
      @(negedge clk);
      start = 1'b1; mdu_op = 3'd0; opr1 = 32'd99; opr2 = 32'd77;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (5) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if ({busy, done, div_zero} !== 3'b000) begin errors++; $display("FAIL async_rst_flags got=%b exp=000", {busy, done, div_zero}); end
      checks++; if ({hi, lo} !== 64'd0) begin errors++; $display("FAIL async_rst_hilo got=%h_%h exp=0", hi, lo); end
      @(negedge clk);
      rst_n = 1'b1;
      m_hi = '0; m_lo = '0; m_dz = 1'b0;
      @(posedge clk); #1;
      checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL async_rst_idle got=%b exp=00", {busy, done}); end
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; abort = 1'b0; mdu_op = 3'd0; opr1 = '0; opr2 = '0;
      m_hi = '0; m_lo = '0; m_dz = 1'b0;
      test_reset();
      test_directed();
      test_move();
      test_back_to_back();
      test_random();
      test_abort();
      test_macc();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/iter_muldiv.md
Name: iter_muldiv

Overview:
- Parametrised multi-cycle multiply/divide unit beside the combinational ALU in the execute stage.
- Performs signed/unsigned multiply and divide by radix-2 iteration, one bit per cycle.
- Owns the HI/LO result registers and exposes a start/busy/done handshake so the pipeline can stall.
- Generalises width and adds sequential behaviour, divide-by-zero reporting and abort.

Parameters:
- WIDTH, 32, operand width in bits; HI and LO are each WIDTH bits; legal values are 8..64, even.
- CNT_W, $clog2(WIDTH+1), width of the iteration counter; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only when busy=0
- mdu_op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110 MADD, 111 MSUB
- opr1  input  WIDTH  multiplicand / dividend / move source
- opr2  input  WIDTH  multiplier / divisor
- abort  input  1  cancels an in-flight operation
- busy  output  1  operation in progress
- done  output  1  one-cycle completion pulse
- div_zero  output  1  valid with done; divisor was 0
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register

Behaviour:
- Reset (rst_n=0, async): state=IDLE; busy=0; done=0; div_zero=0; hi=0; lo=0; counter=0.
- FSM states and transitions:
  - IDLE: start=1 with a MULT/MULTU/DIV/DIVU op latches operands, op and sign flags at edge E0, then goes to CALC.
  - CALC: runs WIDTH iterations, at edges E1..E_WIDTH, then goes to FIXUP.
  - FIXUP: at edge E_(WIDTH+1), applies sign correction, writes hi/lo, sets done=1 for exactly one cycle, then returns to IDLE.
- Latency and handshake:
  - busy is 1 from after E0 until after E_(WIDTH+1).
  - busy and done are never both 1.
  - Back-to-back: start may be asserted in the same cycle done=1 and is accepted.
  - start while busy=1 is ignored, with no queueing.
- MTHI/MTLO:
  - Single cycle; hi (or lo) is written with opr1 at E0.
  - done pulses the next cycle; busy stays 0.
- Multiply:
  - Shift-add on operand magnitudes; a signed op negates the 2*WIDTH product when the operand signs differ.
  - Result is {hi,lo}, exact for both signednesses; no overflow flag.
- Divide:
  - Restoring division on magnitudes.
  - Quotient truncates toward zero and goes to lo; remainder takes the dividend's sign and goes to hi.
  - Divisor 0: iterations still run (fixed latency); result lo = all ones, hi = opr1, div_zero=1 with done.
  - Signed overflow (most-negative / -1): lo = most-negative, hi = 0, div_zero=0.
- div_zero is cleared on every done that is not a divide-by-zero.
- abort:
  - In CALC or FIXUP, abort=1 returns the FSM to IDLE at the next edge.
  - busy drops, no done pulse is issued, hi/lo keep their old values.
  - Ignored in IDLE.
- Width rules:
  - All internal accumulators are 2*WIDTH+1 bits.
  - Negating the most-negative operand uses the unsigned magnitude 2^(WIDTH-1).

Optional Feature:
- Macro: ITER_MULDIV_MACC_EN
- Defined:
  - MADD: {hi,lo} <= {hi,lo} + signed product.
  - MSUB: {hi,lo} <= {hi,lo} - signed product.
  - Both add one ACCUM state after FIXUP, so done arrives one cycle later (after E_(WIDTH+2)).
  - Wrap-around is modulo 2^(2*WIDTH).
- Undefined:
  - Codes 110/111 are treated as no-ops: done pulses the next cycle, busy stays 0, hi/lo are unchanged.

Test Plan (WIDTH=32):
- MULT opr1=0xFFFFFFFE (-2), opr2=3 -> done exactly 33 cycles after the start edge; hi=0xFFFFFFFF, lo=0xFFFFFFFA; MULTU of the same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- DIV opr1=-7 (0xFFFFFFF9), opr2=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); DIVU 7/2 -> lo=3, hi=1; div_zero=0 in both cases.
- DIVU opr1=0x1234, opr2=0 -> lo=0xFFFFFFFF, hi=0x1234, div_zero=1 with done; DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- Start MULT, assert abort at cycle 10 -> busy=0 next cycle, no done, hi/lo unchanged; a second start during busy has no effect on the result of the first.
- MTHI opr1=0xA5A5A5A5 then MTLO opr1=0x5A5A5A5A -> done each on the following cycle, hi/lo as written, busy never 1; async rst_n low mid-CALC -> all outputs 0 immediately.
- With ITER_MULDIV_MACC_EN: MTLO 10, then MADD 3*4 -> lo=22, hi=0, done after 34 cycles; then MSUB 5*5 -> {hi,lo}=0xFFFFFFFF_FFFFFFFD.
